// File: rtl/sevenseg_scan_mux_if.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_mux_if
//
// Bundles the data-side inputs and the pin-side outputs of the multiplexed
// seven-segment driver so the driver and its source connect through a single
// port.
//
//   digits_in  [4*NUM_DIGITS] : BCD/hex digits; digit i at [4i+3:4i], digit 0 rightmost
//   dp_in      [NUM_DIGITS]   : decimal point per digit
//   load                      : one-cycle strobe that captures digits_in/dp_in
//   blank_lz                  : enables leading-zero blanking
//   brightness [BRIGHT_W]     : duty level (0 = 1/2^BRIGHT_W, all-ones = full)
//   sel        [NUM_DIGITS]   : one-hot digit drive, board polarity
//   seg        [7]            : {g,f,e,d,c,b,a}, board polarity
//   dp                        : decimal point, board polarity
//   digit_idx  [clog2(N)]     : slot currently being scanned
//   pending                   : a captured load is waiting for the frame boundary
//   frame_done                : high during the last cycle of each frame
//
// Modports: master = data source (drives the inputs),
//           slave  = the scan driver itself.
// ---------------------------------------------------------------------------
interface sevenseg_scan_mux_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_lz;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   sel;
  logic [6:0]              seg;
  logic                    dp;
  logic [IDX_W-1:0]        digit_idx;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output digits_in, dp_in, load, blank_lz, brightness,
    input  sel, seg, dp, digit_idx, pending, frame_done
  );

  modport slave (
    input  digits_in, dp_in, load, blank_lz, brightness,
    output sel, seg, dp, digit_idx, pending, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_mux.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_mux
//
// Time-multiplexed N-digit seven-segment driver. Each digit owns a slot of
// PHASE_LEN * 2^BRIGHT_W cycles; a frame is NUM_DIGITS slots. Within a slot
// the digit is driven only during phases 0..brightness, which gives the PWM
// dimming. New digit data is captured into a shadow register on load and
// copied to the display register only at the frame wrap, so a frame never
// shows a mix of old and new data.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-low reset (dominant over all inputs)
//   bus    : sevenseg_scan_mux_if.slave
//            inputs  digits_in, dp_in, load, blank_lz, brightness
//            outputs sel, seg, dp (registered, 1-cycle latency),
//                    digit_idx, pending, frame_done
// ---------------------------------------------------------------------------
module sevenseg_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int PHASE_LEN      = 2500,
  parameter int BRIGHT_W       = 4,
  parameter int SEL_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               reset,
  sevenseg_scan_mux_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int DIG_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] SEL_INV = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
  localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);

  // Hex digit to active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Board polarity is applied at the very last step so all internal logic
  // stays active-high.
  function automatic logic [NUM_DIGITS-1:0] sel_to_pins(input logic [NUM_DIGITS-1:0] s);
    return s ^ SEL_INV;
  endfunction

  function automatic logic [6:0] seg_to_pins(input logic [6:0] s);
    return s ^ SEG_INV;
  endfunction

  function automatic logic dp_to_pins(input logic d);
    return d ^ DP_INV;
  endfunction

  // ---- stage p0: scan counters ----
  logic [CNT_W-1:0]    phase_cnt_p0;
  logic [BRIGHT_W-1:0] phase_p0;
  logic [IDX_W-1:0]    digit_idx_p0;
  logic                cnt_last;
  logic                phase_last;
  logic                frame_wrap;

  assign cnt_last   = (phase_cnt_p0 == CNT_LAST);
  assign phase_last = cnt_last && (phase_p0 == '1);
  assign frame_wrap = phase_last && (digit_idx_p0 == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_cnt_p0 <= '0;
      phase_p0     <= '0;
      digit_idx_p0 <= '0;
    end else begin
      phase_cnt_p0 <= cnt_last ? '0 : phase_cnt_p0 + 1'b1;
      // phase is a full-width power-of-two counter, so it wraps by itself
      if (cnt_last) begin
        phase_p0 <= phase_p0 + 1'b1;
      end
      if (phase_last) begin
        digit_idx_p0 <= (digit_idx_p0 == IDX_LAST) ? '0 : digit_idx_p0 + 1'b1;
      end
    end
  end

  // ---- shadow (pending) and display registers ----
  logic [DIG_W-1:0]      pend_dig;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pending_q;
  logic [DIG_W-1:0]      disp_dig;
  logic [NUM_DIGITS-1:0] disp_dp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_dig  <= '0;
      pend_dp   <= '0;
      pending_q <= 1'b0;
      disp_dig  <= '0;
      disp_dp   <= '0;
    end else if (frame_wrap) begin
      // A load coinciding with the wrap bypasses the shadow register and
      // is shown in the frame that starts at this edge.
      if (bus.load) begin
        disp_dig <= bus.digits_in;
        disp_dp  <= bus.dp_in;
      end else if (pending_q) begin
        disp_dig <= pend_dig;
        disp_dp  <= pend_dp;
      end
      pending_q <= 1'b0;
    end else if (bus.load) begin
      pend_dig  <= bus.digits_in;
      pend_dp   <= bus.dp_in;
      pending_q <= 1'b1;
    end
  end

  // Select the digit for the current slot and decide whether it is a
  // leading zero. lz_run stays high while every digit from the top down to
  // the one being examined is zero.
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_blank;
  logic       lz_run;

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    lz_run    = bus.blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (disp_dig[4*i +: 4] == 4'h0);
      if (digit_idx_p0 == IDX_W'(i)) begin
        cur_nib   = disp_dig[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = (i != 0) && lz_run;
      end
    end
  end

  logic                  drive_on;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  // brightness is used live; phase 0 is always lit, so even level 0 shows.
  assign drive_on = (phase_p0 <= bus.brightness);

  always_comb begin
    sel_next = '0;
    seg_next = '0;
    dp_next  = 1'b0;
    if (drive_on) begin
      sel_next = NUM_DIGITS'(1) << digit_idx_p0;
      seg_next = cur_blank ? 7'b0000000 : hex_to_seg(cur_nib);
      dp_next  = cur_dp;
    end
  end

  // ---- stage p1: registered pin drive ----
  logic [NUM_DIGITS-1:0] sel_p1;
  logic [6:0]            seg_p1;
  logic                  dp_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_p1 <= sel_to_pins('0);
      seg_p1 <= seg_to_pins('0);
      dp_p1  <= dp_to_pins(1'b0);
    end else begin
      sel_p1 <= sel_to_pins(sel_next);
      seg_p1 <= seg_to_pins(seg_next);
      dp_p1  <= dp_to_pins(dp_next);
    end
  end

  assign bus.sel        = sel_p1;
  assign bus.seg        = seg_p1;
  assign bus.dp         = dp_p1;
  assign bus.digit_idx  = digit_idx_p0;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_wrap;

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Scoreboard bench for sevenseg_scan_mux (4 digits, PHASE_LEN=2, BRIGHT_W=2,
// active-high pins). The stimulus process advances a cycle-count based
// reference model and queues the expected pin state; the monitor pops and
// compares on every falling edge.
module tb_sevenseg_scan_mux;
  localparam int N     = 4;
  localparam int PL    = 2;
  localparam int BW    = 2;
  localparam int SLOT  = PL * (1 << BW);
  localparam int FRAME = N * SLOT;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       pend;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sevenseg_scan_mux_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

  sevenseg_scan_mux #(
    .NUM_DIGITS(N), .PHASE_LEN(PL), .BRIGHT_W(BW),
    .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // stimulus variables applied on the next tick
  logic        r_n  = 1'b0;
  logic        ld   = 1'b0;
  logic        blz  = 1'b0;
  logic [15:0] din  = '0;
  logic [3:0]  dpin = '0;
  logic [1:0]  br   = 2'd3;

  // reference model state: m_t = cycles since reset released
  int          m_t = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_dispdp = '0, m_penddp = '0;
  logic        m_pending = 1'b0;
  logic [3:0]  m_sel = '0;
  logic [6:0]  m_seg = '0;
  logic        m_dp = 1'b0;

  function automatic void model_out(output logic [3:0] s, output logic [6:0] g, output logic d);
    int digit;
    int phase;
    logic [15:0] upper;
    digit = (m_t / SLOT) % N;
    phase = (m_t / PL) % (1 << BW);
    upper = m_disp >> (4 * digit);
    s = '0;
    g = '0;
    d = 1'b0;
    if (phase <= int'(br)) begin
      s = 4'(1 << digit);
      d = m_dispdp[digit];
      if (blz && digit >= 1 && upper == 16'h0) g = 7'h00;
      else g = glyph[upper[3:0]];
    end
  endfunction

  task automatic tick();
    exp_t e;
    logic [3:0] s;
    logic [6:0] g;
    logic d;
    e.sel  = m_sel;
    e.seg  = m_seg;
    e.dp   = m_dp;
    e.idx  = 2'((m_t / SLOT) % N);
    e.pend = m_pending;
    e.fd   = (m_t % FRAME == FRAME - 1);
    q.push_back(e);
    reset          = r_n;
    bus.load       = ld;
    bus.digits_in  = din;
    bus.dp_in      = dpin;
    bus.blank_lz   = blz;
    bus.brightness = br;
    if (!r_n) begin
      m_t = 0; m_disp = '0; m_dispdp = '0; m_pend = '0; m_penddp = '0;
      m_pending = 1'b0; m_sel = '0; m_seg = '0; m_dp = 1'b0;
    end else begin
      model_out(s, g, d);
      if (m_t % FRAME == FRAME - 1) begin
        if (ld) begin
          m_disp = din; m_dispdp = dpin;
        end else if (m_pending) begin
          m_disp = m_pend; m_dispdp = m_penddp;
        end
        m_pending = 1'b0;
      end else if (ld) begin
        m_pend = din; m_penddp = dpin; m_pending = 1'b1;
      end
      m_sel = s; m_seg = g; m_dp = d;
      m_t++;
    end
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    din = d; dpin = p; ld = 1'b1;
    tick();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sel", 16'(bus.sel), 16'(e.sel));
        chk("seg", 16'(bus.seg), 16'(e.seg));
        chk("dp", 16'(bus.dp), 16'(e.dp));
        chk("digit_idx", 16'(bus.digit_idx), 16'(e.idx));
        chk("pending", 16'(bus.pending), 16'(e.pend));
        chk("frame_done", 16'(bus.frame_done), 16'(e.fd));
      end
    end
  end

  initial begin : stim
    reset = 1'b0;
    bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;
    bus.blank_lz = 1'b0; bus.brightness = 2'd3;
    @(posedge clk);
    #1;
    // reset held, then a free-running frame with no data
    r_n = 1'b0;
    repeat (2) tick();
    r_n = 1'b1;
    repeat (40) tick();
    // basic decode with a decimal point, shadowed until the wrap
    br = 2'd3;
    do_load(16'h1234, 4'b0100);
    repeat (2 * FRAME) tick();
    // leading-zero blanking
    blz = 1'b1;
    do_load(16'h0007, 4'b0000);
    repeat (2 * FRAME) tick();
    do_load(16'h0000, 4'b0000);
    repeat (2 * FRAME) tick();
    blz = 1'b0;
    repeat (FRAME) tick();
    // brightness levels
    do_load(16'h5A0C, 4'b1001);
    br = 2'd0; repeat (2 * FRAME) tick();
    br = 2'd1; repeat (FRAME) tick();
    br = 2'd2; repeat (FRAME) tick();
    br = 2'd3; repeat (FRAME) tick();
    // two loads in one frame: last wins
    while (m_t % FRAME != 0) tick();
    repeat (3) tick();
    do_load(16'hAAAA, 4'b1111);
    repeat (5) tick();
    do_load(16'hBEEF, 4'b0010);
    repeat (2 * FRAME) tick();
    // load exactly on the wrap cycle
    while (m_t % FRAME != FRAME - 1) tick();
    do_load(16'hC0DE, 4'b0001);
    repeat (FRAME + 4) tick();
    // reset in the middle of slot 2
    while (!(((m_t / SLOT) % N == 2) && (m_t % SLOT == 3))) tick();
    r_n = 1'b0;
    tick();
    r_n = 1'b1;
    repeat (FRAME + 8) tick();
    // randomized traffic
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 39) == 0) br = 2'($urandom);
      if ($urandom_range(0, 59) == 0) blz = ~blz;
      if ($urandom_range(0, 399) == 0) r_n = 1'b0;
      else r_n = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        din  = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dpin = 4'($urandom);
        ld   = 1'b1;
      end
      tick();
    end
    r_n = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
